// File: rtl/m_issue_ctrl.sv
// M-extension issue controller: decodes RV32M ops, holds operands for the unit,
// stalls the core while busy and returns a one-cycle writeback strobe.
module m_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        flush,
  input  logic [31:0] m_result,
  input  logic        m_done,
  input  logic        m_busy,
  output logic [3:0]  mul_con,
  output logic [31:0] operand_a,
  output logic [31:0] operand_b,
  output logic        m_kill,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        m_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [3:0]    con_q;
  logic [31:0]   opa_q, opb_q;
  logic          wbv_q;
  logic [4:0]    rd_q;
  logic [31:0]   wbd_q;
  logic          tmo_q;

  logic [2:0]    f3;
  logic          is_m;
  logic          accept;
  logic          tmo_hit;
  logic [3:0]    con_map;
  logic          unused_instr;

  assign f3     = instr[14:12];
  assign is_m   = instr_valid
                & (instr[6:0] == 7'b0110011)
                & (instr[31:25] == 7'b0000001);
  assign accept = (state_q == IDLE) & is_m & ~flush & ~m_busy;
  assign tmo_hit = (state_q == BUSY) & ~flush & ~m_done
                 & (cnt_q == CNT_LAST);
  assign unused_instr = ^instr[24:15];

  // funct3 to unit opcode
  always_comb begin
    con_map = 4'b0000;
    unique case (f3)
      3'b000: con_map = 4'b0001;
      3'b001: con_map = 4'b0010;
      3'b010: con_map = 4'b0100;
      3'b011: con_map = 4'b0011;
      3'b100: con_map = 4'b1000;
      3'b101: con_map = 4'b1001;
      3'b110: con_map = 4'b1010;
      3'b111: con_map = 4'b1011;
      default: con_map = 4'b0000;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state: flush beats done beats timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (flush)        state_d = IDLE;
        else if (m_done)  state_d = WB;
        else if (tmo_hit) state_d = IDLE;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // combinational handshake outputs
  always_comb begin
    stall  = 1'b0;
    m_kill = 1'b0;
    unique case (state_q)
      IDLE: stall = is_m & ~flush;
      BUSY: begin
        stall  = 1'b1;
        m_kill = flush | tmo_hit;
      end
      default: ;
    endcase
  end

  // operand, opcode, counter and writeback registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      con_q <= 4'b0000;
      opa_q <= '0;
      opb_q <= '0;
      wbv_q <= 1'b0;
      rd_q  <= '0;
      wbd_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      wbv_q <= 1'b0;
      tmo_q <= 1'b0;
      if (accept) begin
        opa_q <= rs1_data;
        opb_q <= rs2_data;
        con_q <= con_map;
        rd_q  <= instr[11:7];
        cnt_q <= '0;
      end
      if (state_q == BUSY) begin
        cnt_q <= cnt_q + 1'b1;
        if (flush) begin
          con_q <= 4'b0000;
        end else if (m_done) begin
          wbd_q <= m_result;
          wbv_q <= (rd_q != 5'd0);
          con_q <= 4'b0000;
        end else if (tmo_hit) begin
          tmo_q <= 1'b1;
          con_q <= 4'b0000;
        end
      end
    end
  end

  assign mul_con   = con_q;
  assign operand_a = opa_q;
  assign operand_b = opb_q;
  assign wb_valid  = wbv_q;
  assign wb_rd     = rd_q;
  assign wb_data   = wbd_q;
  assign m_timeout = tmo_q;

endmodule
